apb_master_arb: RTL and testbench
=================================

APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 The block SHALL have one clock, pclk, and an asynchronous active-low reset, preset_n.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, SHALL set the maximum number of ACCESS cycles per transfer when the timeout is compiled in (legal range 2..255).
REQ-003 Port list (name  direction  width  meaning):
- pclk  in  1  APB clock.
- preset_n  in  1  async active-low reset.
- req_valid  in  2  per-requester transfer request; bit i = requester i.
- req_write  in  2  per-requester direction, 1 = write.
- req_addr  in  18  requester i address at bits [9i+8:9i].
- req_wdata  in  64  requester i write data at bits [32i+31:32i].
- req_done  out  2  one-cycle completion strobe per requester.
- req_err  out  2  timeout flag, valid with req_done.
- req_rdata  out  32  read data, valid when req_done is high for a read.
- paddr  out  9  APB address.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  32  APB write data.
- pready  in  1  APB slave ready.
- prdata  in  32  APB read data.

Function
REQ-004 The FSM SHALL have states IDLE, SETUP and ACCESS; psel, penable, paddr, pwrite and pwdata SHALL be driven from registers.
REQ-005 In IDLE with any req_valid high, the FSM SHALL latch the granted requester's addr/write/wdata, assert psel with penable low on the next cycle, and enter SETUP.
REQ-006 Arbitration SHALL be round-robin: a lone requester is granted; when both are valid, the requester other than last_grant is granted; last_grant resets to 1, so requester 0 wins first.
REQ-007 SETUP SHALL always advance to ACCESS after one cycle, asserting penable with psel, paddr, pwrite and pwdata unchanged.
REQ-008 In ACCESS with pready low, all bus outputs SHALL hold.
REQ-009 In ACCESS with pready high, req_done[grant] SHALL be high combinationally in that cycle, req_rdata SHALL equal prdata, and last_grant SHALL update to grant.
REQ-010 On completion, if the other requester's req_valid is high, the FSM SHALL go directly to SETUP for it (psel stays high, penable low for one cycle); otherwise it SHALL go to IDLE with psel and penable low.
REQ-011 A requester's own req_valid SHALL be ignored in its completion cycle; it is re-arbitrated from IDLE or on the next completion.
REQ-012 Requesters SHALL hold valid, write, addr and wdata stable until their req_done cycle inclusive.
REQ-013 req_rdata SHALL be don't-care when no read completes; req_done SHALL never be high for both bits at once.

Reset
REQ-014 preset_n low SHALL immediately force state IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, last_grant=1, timeout counter=0 and req_done=req_err=0.
REQ-015 Reset asserted mid-transfer SHALL abandon the transfer without a req_done; after release, pending requests are arbitrated from IDLE.

Configuration
REQ-016 With APB_ARB_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles; if pready is still low in the TIMEOUT_CYCLES-th ACCESS cycle, req_done[grant] and req_err[grant] SHALL pulse together, and the FSM SHALL return to IDLE with no back-to-back transfer.
REQ-017 With APB_ARB_TIMEOUT_EN undefined, ACCESS SHALL wait indefinitely for pready, req_err SHALL be tied to 0, and TIMEOUT_CYCLES SHALL be ignored.

Verification
REQ-018 Requester 0 writes 0xDEADBEEF to 0x1A4 with pready=1 -> psel high at cycle 1, penable high at cycle 2 with req_done[0], psel/penable low at cycle 3.
REQ-019 Requester 1 reads 0x010 with pready low for 3 ACCESS cycles, then high with prdata=0x12345678 -> req_done[1] with req_rdata=0x12345678 in the 4th ACCESS cycle.
REQ-020 Both requesters valid continuously from reset for 4 transfers -> grant order 0,1,0,1, psel never drops, penable low exactly one cycle between transfers.
REQ-021 APB_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, pready stuck at 0 -> req_done[0]=req_err[0]=1 in the 4th ACCESS cycle, psel=0 next cycle; macro undefined -> psel/penable held 20 cycles with no req_done.
REQ-022 preset_n pulsed low during ACCESS -> all outputs 0 asynchronously with no req_done; a still-valid requester 0 gets psel one cycle after release.

Source files
------------

// File: rtl/apb_master_arb.sv
// Two-requester APB master with round-robin arbitration and back-to-back transfers.
// Optional ACCESS-phase timeout is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_master_arb #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        pclk,
    input  logic        preset_n,
    input  logic [1:0]  req_valid,
    input  logic [1:0]  req_write,
    input  logic [17:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic [1:0]  req_done,
    output logic [1:0]  req_err,
    output logic [31:0] req_rdata,
    output logic [8:0]  paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic        pready,
    input  logic [31:0] prdata
);

    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 255)) begin : g_bad_timeout
        $error("apb_master_arb: TIMEOUT_CYCLES must be in 2..255");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t      r_state, w_state_nxt;
    logic        r_grant, r_last_grant;
    logic        r_psel, r_penable, r_pwrite;
    logic [8:0]  r_paddr;
    logic [31:0] r_pwdata;

    logic        w_arb_sel, w_other;
    logic        w_load, w_load_sel, w_complete, w_timeout;
    logic [1:0]  w_grant_onehot;

    // Both valid: alternate away from the last winner; otherwise the lone requester wins.
    assign w_arb_sel      = (req_valid == 2'b11) ? ~r_last_grant : req_valid[1];
    assign w_other        = ~r_grant;
    assign w_grant_onehot = r_grant ? 2'b10 : 2'b01;

`ifdef APB_ARB_TIMEOUT_EN
    logic [7:0] r_tcnt;

    // r_tcnt holds (ACCESS cycle number - 1) while in ACCESS.
    assign w_timeout = (r_state == ACCESS) && !pready &&
                       (r_tcnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_tcnt <= '0;
        end else if ((r_state == ACCESS) && !w_complete) begin
            r_tcnt <= r_tcnt + 8'd1;
        end else begin
            r_tcnt <= '0;
        end
    end

    assign req_err = w_timeout ? w_grant_onehot : 2'b00;
`else
    assign w_timeout = 1'b0;
    assign req_err   = 2'b00;
`endif

    // NOTE: every output of this block is given a default first, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_sel  = w_arb_sel;
        w_complete  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (|req_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = SETUP;
                end
            end
            SETUP: w_state_nxt = ACCESS;
            ACCESS: begin
                if (pready) begin
                    w_complete = 1'b1;
                    if (req_valid[w_other]) begin
                        w_load      = 1'b1;
                        w_load_sel  = w_other;
                        w_state_nxt = SETUP;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (w_timeout) begin
                    w_complete  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state      <= IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_complete) begin
                r_last_grant <= r_grant;
            end
            if (w_load) begin
                r_grant   <= w_load_sel;
                r_psel    <= 1'b1;
                r_penable <= 1'b0;
                r_pwrite  <= req_write[w_load_sel];
                r_paddr   <= w_load_sel ? req_addr[17:9]   : req_addr[8:0];
                r_pwdata  <= w_load_sel ? req_wdata[63:32] : req_wdata[31:0];
            end else if (r_state == SETUP) begin
                r_penable <= 1'b1;
            end else if (w_complete) begin
                r_psel    <= 1'b0;
                r_penable <= 1'b0;
            end
        end
    end

    assign req_done  = w_complete ? w_grant_onehot : 2'b00;
    assign req_rdata = prdata;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;

endmodule

// File: tb/tb_apb_master_arb.sv
// Self-checking bench for apb_master_arb: vector table, back-to-back, timeout/hold and reset cases.
module tb_apb_master_arb;

    localparam int TO = 4;

    logic        pclk = 1'b0;
    logic        preset_n;
    logic [1:0]  req_valid, req_write;
    logic [17:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_done, req_err;
    logic [31:0] req_rdata;
    logic [8:0]  paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;

    apb_master_arb #(.TIMEOUT_CYCLES(TO)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata),
        .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata),
        .pready(pready), .prdata(prdata)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        id;
        logic        err;
        logic        write;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic        id;
        logic        write;
        logic [8:0]  addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] prdata;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

    // Scoreboard: every completion strobe must match the oldest expected transfer.
    always @(negedge pclk) begin : monitor
        exp_t e;
        #2;
        if (req_done !== 2'b00) begin
            check("done_onehot", 64'(req_done == 2'b01 || req_done == 2'b10), 64'd1);
            if (sb_q.size() == 0) begin
                check("done_unexpected", 64'(req_done), 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("done_id", 64'(req_done), 64'(onehot(e.id)));
                check("done_err", 64'(req_err), e.err ? 64'(onehot(e.id)) : 64'd0);
                if (!e.write && !e.err) check("rdata", 64'(req_rdata), 64'(e.rdata));
            end
        end else if (req_err !== 2'b00) begin
            check("err_without_done", 64'(req_err), 64'd0);
        end
    end

    task automatic push_exp(input logic id, input logic err, input logic write, input logic [31:0] rd);
        exp_t e;
        e.id = id; e.err = err; e.write = write; e.rdata = rd;
        sb_q.push_back(e);
    endtask

    task automatic reset_pulse();
        @(negedge pclk);
        preset_n = 1'b0;
        @(negedge pclk);
        preset_n = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge pclk);
        req_valid              = 2'b00;
        req_valid[v.id]        = 1'b1;
        req_write[v.id]        = v.write;
        req_addr[v.id*9 +: 9]  = v.addr;
        req_wdata[v.id*32 +: 32] = v.wdata;
        pready                 = 1'b0;
        push_exp(v.id, 1'b0, v.write, v.prdata);
        @(negedge pclk);
        check("setup_psel", 64'(psel), 64'd1);
        check("setup_penable", 64'(penable), 64'd0);
        check("setup_paddr", 64'(paddr), 64'(v.addr));
        check("setup_pwrite", 64'(pwrite), 64'(v.write));
        if (v.write) check("setup_pwdata", 64'(pwdata), 64'(v.wdata));
        for (int w = 0; w <= v.waits; w++) begin
            @(negedge pclk);
            pready = (w == v.waits);
            prdata = pready ? v.prdata : ~v.prdata;
            #1;
            check("access_psel", 64'(psel), 64'd1);
            check("access_penable", 64'(penable), 64'd1);
            check("access_paddr", 64'(paddr), 64'(v.addr));
            check("access_done", 64'(req_done), (w == v.waits) ? 64'(onehot(v.id)) : 64'd0);
        end
        @(posedge pclk);
        #1;
        req_valid = 2'b00;
        pready    = 1'b0;
        @(negedge pclk);
        check("idle_psel", 64'(psel), 64'd0);
        check("idle_penable", 64'(penable), 64'd0);
    endtask

    task automatic back_to_back();
        logic g;
        reset_pulse();
        @(negedge pclk);
        req_valid = 2'b11;
        req_write = 2'b11;
        req_addr  = {9'h1AA, 9'h055};
        req_wdata = {32'h2222_0001, 32'h1111_0000};
        pready    = 1'b1;
        for (int t = 0; t < 4; t++) push_exp(t[0], 1'b0, 1'b1, 32'h0);
        for (int t = 0; t < 4; t++) begin
            g = t[0];
            @(negedge pclk);
            check("b2b_setup_psel", 64'(psel), 64'd1);
            check("b2b_setup_penable", 64'(penable), 64'd0);
            check("b2b_setup_paddr", 64'(paddr), g ? 64'h1AA : 64'h055);
            if (t == 3) req_valid[0] = 1'b0;
            @(negedge pclk);
            #1;
            check("b2b_access_psel", 64'(psel), 64'd1);
            check("b2b_access_penable", 64'(penable), 64'd1);
            check("b2b_grant_order", 64'(req_done), 64'(onehot(g)));
        end
        @(posedge pclk);
        #1;
        req_valid = 2'b00;
        pready    = 1'b0;
        @(negedge pclk);
        check("b2b_end_psel", 64'(psel), 64'd0);
    endtask

    task automatic stall_test();
        reset_pulse();
        @(negedge pclk);
        req_valid     = 2'b01;
        req_write     = 2'b00;
        req_addr[8:0] = 9'h0F0;
        pready        = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
        push_exp(1'b0, 1'b1, 1'b0, 32'h0);
        @(negedge pclk);
        check("to_setup_psel", 64'(psel), 64'd1);
        for (int k = 1; k <= TO; k++) begin
            @(negedge pclk);
            if (k == 1) req_valid[1] = 1'b1;
            #1;
            check("to_done", 64'(req_done), (k == TO) ? 64'd1 : 64'd0);
            check("to_err", 64'(req_err), (k == TO) ? 64'd1 : 64'd0);
        end
        @(posedge pclk);
        #1;
        req_valid = 2'b00;
        @(negedge pclk);
        check("to_psel_after", 64'(psel), 64'd0);
        check("to_penable_after", 64'(penable), 64'd0);
`else
        @(negedge pclk);
        check("hold_setup_psel", 64'(psel), 64'd1);
        for (int k = 1; k <= 20; k++) begin
            @(negedge pclk);
            #1;
            check("hold_bus", {62'd0, psel, penable}, 64'd3);
            check("hold_no_done", 64'(req_done), 64'd0);
            check("hold_no_err", 64'(req_err), 64'd0);
        end
        @(negedge pclk);
        push_exp(1'b0, 1'b0, 1'b0, 32'h0BAD_F00D);
        pready = 1'b1;
        prdata = 32'h0BAD_F00D;
        #1;
        check("hold_release_done", 64'(req_done), 64'd1);
        @(posedge pclk);
        #1;
        req_valid = 2'b00;
        pready    = 1'b0;
        @(negedge pclk);
        check("hold_end_psel", 64'(psel), 64'd0);
`endif
    endtask

    task automatic reset_in_access();
        @(negedge pclk);
        req_valid     = 2'b01;
        req_write     = 2'b01;
        req_addr[8:0] = 9'h123;
        req_wdata[31:0] = 32'h5A5A_C3C3;
        pready        = 1'b0;
        @(negedge pclk);
        check("rst_setup_psel", 64'(psel), 64'd1);
        @(negedge pclk);
        #3;
        check("rst_pre_penable", 64'(penable), 64'd1);
        preset_n = 1'b0;
        #1;
        check("rst_psel", 64'(psel), 64'd0);
        check("rst_penable", 64'(penable), 64'd0);
        check("rst_pwrite", 64'(pwrite), 64'd0);
        check("rst_paddr", 64'(paddr), 64'd0);
        check("rst_pwdata", 64'(pwdata), 64'd0);
        check("rst_done", 64'(req_done), 64'd0);
        @(negedge pclk);
        preset_n = 1'b1;
        @(negedge pclk);
        check("rst_rearb_psel", 64'(psel), 64'd1);
        check("rst_rearb_penable", 64'(penable), 64'd0);
        check("rst_rearb_paddr", 64'(paddr), 64'h123);
        push_exp(1'b0, 1'b0, 1'b1, 32'h0);
        @(negedge pclk);
        pready = 1'b1;
        #1;
        check("rst_rearb_done", 64'(req_done), 64'd1);
        @(posedge pclk);
        #1;
        req_valid = 2'b00;
        pready    = 1'b0;
        @(negedge pclk);
        check("rst_end_psel", 64'(psel), 64'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        preset_n  = 1'b0;
        req_valid = 2'b00;
        req_write = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        pready    = 1'b0;
        prdata    = '0;
        #1;
        check("reset_psel", 64'(psel), 64'd0);
        check("reset_penable", 64'(penable), 64'd0);
        check("reset_pwrite", 64'(pwrite), 64'd0);
        check("reset_paddr", 64'(paddr), 64'd0);
        check("reset_pwdata", 64'(pwdata), 64'd0);
        check("reset_done", 64'(req_done), 64'd0);
        check("reset_err", 64'(req_err), 64'd0);
        @(negedge pclk);
        @(negedge pclk);
        preset_n = 1'b1;

        vecs[0] = '{id: 1'b0, write: 1'b1, addr: 9'h1A4, wdata: 32'hDEAD_BEEF, waits: 0, prdata: 32'h0};
        vecs[1] = '{id: 1'b1, write: 1'b0, addr: 9'h010, wdata: 32'h0,         waits: 3, prdata: 32'h1234_5678};
        vecs[2] = '{id: 1'b1, write: 1'b1, addr: 9'h1FF, wdata: 32'hA5A5_0F0F, waits: 1, prdata: 32'h0};
        vecs[3] = '{id: 1'b0, write: 1'b0, addr: 9'h000, wdata: 32'h0,         waits: 2, prdata: 32'hCAFE_F00D};
        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        back_to_back();
        stall_test();
        reset_in_access();

        repeat (2) @(negedge pclk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
